// File: rtl/cpstr_pkg.sv
// Shared definitions for the control-plane stream mux family.
package cpstr_pkg;

    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'd27;

    typedef enum logic [2:0] {
        ARB,
        HDR_ESC,
        HDR_IDX,
        DATA,
        DUP_ESC
    } state_t;

    function automatic logic is_esc(input logic [7:0] b, input logic [7:0] esc);
        return b == esc;
    endfunction

endpackage

// File: rtl/cpstr_rr_arb.sv
// Combinational rotating-priority arbiter: search starts at last+1 and wraps through last.
module cpstr_rr_arb
    import cpstr_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [LW-1:0] k;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = LW'((32'(last) + i) % N);
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = k;
            end
        end
    end

endmodule

// File: rtl/cpstr_wmux_tx.sv
// Weighted escaped-stream multiplexer: merges byte streams into one ESC-framed link
// with per-stream burst weights and optional periodic stream-select refresh.
module cpstr_wmux_tx
    import cpstr_pkg::*;
#(
    parameter int unsigned NUM_STREAMS   = 3,
    parameter logic [7:0]  ESC_CHAR      = ESC_CHAR_DEFAULT,
    parameter int unsigned BURST_W       = 8,
    parameter int unsigned STRIDX_PERIOD = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [8*NUM_STREAMS-1:0]       i_data,
    input  logic [NUM_STREAMS-1:0]         i_valid,
    output logic [NUM_STREAMS-1:0]         o_ready,
    input  logic [BURST_W*NUM_STREAMS-1:0] i_burst,
    output logic [7:0]                     o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    input  logic                           i_emit_stridx,
    output logic [7:0]                     o_cur_stridx
);

    localparam int unsigned IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int unsigned PW = (STRIDX_PERIOD > 1) ? $clog2(STRIDX_PERIOD + 1) : 1;
    localparam logic [PW-1:0] PERIOD = PW'(STRIDX_PERIOD);

    state_t               state;
    logic [IW-1:0]        cur;
    logic [BURST_W-1:0]   burst_cur;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 hdr_pending;
    logic [PW-1:0]        period_cnt;

    logic                 free;
    logic                 take_ok;
    logic                 period_hit;
    logic                 cand_any;
    logic [IW-1:0]        cand_idx;
    logic [NUM_STREAMS-1:0] eligible;
    logic [7:0]           cur_data;
    logic [BURST_W-1:0]   cand_burst;

    assign free         = !o_valid || i_ready;
    assign take_ok      = (state == DATA) && free && (burst_cnt < burst_cur);
    assign period_hit   = (STRIDX_PERIOD != 0) && (period_cnt == PERIOD);
    assign o_cur_stridx = 8'(cur);

    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++)
            eligible[k] = i_valid[k] && (i_burst[k*BURST_W +: BURST_W] != '0);
    end

    always_comb begin
        cur_data   = '0;
        cand_burst = '0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
            if (IW'(k) == cur)      cur_data   = i_data[k*8 +: 8];
            if (IW'(k) == cand_idx) cand_burst = i_burst[k*BURST_W +: BURST_W];
        end
    end

    always_comb begin
        o_ready = '0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++)
            o_ready[k] = take_ok && (IW'(k) == cur);
    end

    cpstr_rr_arb #(.N(NUM_STREAMS)) u_arb (
        .req     (eligible),
        .last    (cur),
        .gnt_idx (cand_idx),
        .gnt_any (cand_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ARB;
            cur         <= '0;
            burst_cur   <= '0;
            burst_cnt   <= '0;
            hdr_pending <= 1'b1;
            period_cnt  <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
        end else begin
            if (o_valid && i_ready) o_valid <= 1'b0;
            if (o_valid && i_ready && !period_hit) period_cnt <= period_cnt + 1'b1;
            if (period_hit || i_emit_stridx) hdr_pending <= 1'b1;

            case (state)
                ARB: begin
                    if (cand_any) begin
                        burst_cur <= cand_burst;
                        burst_cnt <= '0;
                        cur       <= cand_idx;
                        // refresh requests arriving this cycle are folded into the decision
                        state <= (cand_idx != cur || hdr_pending || i_emit_stridx || period_hit)
                                 ? HDR_ESC : DATA;
                    end
                end
                HDR_ESC: begin
                    if (free) begin
                        o_data  <= ESC_CHAR;
                        o_valid <= 1'b1;
                        state   <= HDR_IDX;
                    end
                end
                HDR_IDX: begin
                    if (free) begin
                        o_data      <= 8'(cur);
                        o_valid     <= 1'b1;
                        hdr_pending <= i_emit_stridx;
                        period_cnt  <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (take_ok && i_valid[cur]) begin
                        o_data    <= cur_data;
                        o_valid   <= 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (is_esc(cur_data, ESC_CHAR)) state <= DUP_ESC;
                    end else if (burst_cnt == burst_cur || (free && !i_valid[cur])) begin
                        state <= ARB;
                    end
                end
                DUP_ESC: begin
                    if (free) begin
                        o_data  <= ESC_CHAR;
                        o_valid <= 1'b1;
                        state   <= DATA;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_cpstr_wmux_tx.sv
// Bench for cpstr_wmux_tx: output byte stream compared against a grant-level framing model.
module tb_cpstr_wmux_tx;

    localparam int N = 3;
    localparam logic [7:0] ESC = 8'h1B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ovalid, ready_i, emit;
    logic [23:0] data, burst;
    logic [2:0]  valid, ready_o;
    logic [7:0]  odata, cur_o;

    logic        p_rst, p_ovalid, p_ready_i, p_emit;
    logic [23:0] p_data, p_burst;
    logic [2:0]  p_valid, p_ready_o;
    logic [7:0]  p_odata, p_cur_o;

    cpstr_wmux_tx #(.NUM_STREAMS(3), .ESC_CHAR(8'd27), .BURST_W(8), .STRIDX_PERIOD(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready_o),
        .i_burst(burst), .o_data(odata), .o_valid(ovalid), .i_ready(ready_i),
        .i_emit_stridx(emit), .o_cur_stridx(cur_o)
    );

    cpstr_wmux_tx #(.NUM_STREAMS(3), .ESC_CHAR(8'd27), .BURST_W(8), .STRIDX_PERIOD(16)) dut_p (
        .i_clk(clk), .i_rst(p_rst), .i_data(p_data), .i_valid(p_valid), .o_ready(p_ready_o),
        .i_burst(p_burst), .o_data(p_odata), .o_valid(p_ovalid), .i_ready(p_ready_i),
        .i_emit_stridx(p_emit), .o_cur_stridx(p_cur_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] src [3][128];
    logic [7:0] psrc [128];
    logic [7:0] mdl_q[$], exp_q[$], got_q[$], pgot_q[$];
    int ptr [3];
    int pptr;
    logic [2:0] en;
    int cfg_b [3];
    int nwant, emit_at, emit_after, stall_at, stall_left;
    bit emit_done, rand_ready, prev_hold, p_done;
    logic [7:0] prev_data;

    function automatic logic [7:0] rbyte();
        return ($urandom_range(0, 7) == 0) ? ESC : 8'($urandom_range(0, 255));
    endfunction

    // Expected link bytes: round-robin grants of burst[k] source bytes each, framed by ESC rules.
    task automatic build_model(input bit usep, input logic [2:0] m, input int b0, input int b1,
                               input int b2, input int period, input int emit_g, input int nmax);
        int bw [3];
        int mp [3];
        int cur, cnt, grant, w, k;
        bit pend;
        logic [7:0] d;
        bw = '{b0, b1, b2};
        mp = '{0, 0, 0};
        cur = 0; pend = 1'b1; cnt = 0; grant = 0;
        mdl_q.delete();
        while (mdl_q.size() < nmax) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                k = (cur + i) % N;
                if (w < 0 && m[k] && bw[k] > 0) w = k;
            end
            if (w < 0) break;
            if (period > 0 && cnt >= period) pend = 1'b1;
            if (grant == emit_g) pend = 1'b1;
            if (w != cur || pend) begin
                mdl_q.push_back(ESC);
                mdl_q.push_back(8'(w));
                cnt = 1;
                pend = 1'b0;
            end
            cur = w;
            for (int j = 0; j < bw[w]; j++) begin
                d = usep ? psrc[mp[w]] : src[w][mp[w]];
                mp[w]++;
                mdl_q.push_back(d);
                cnt++;
                if (d == ESC) begin
                    mdl_q.push_back(ESC);
                    cnt++;
                end
            end
            grant++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = '0; emit = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_o_valid", 32'(ovalid), 0);
        check("rst_o_ready", 32'(ready_o), 0);
        check("rst_o_data", 32'(odata), 0);
        check("rst_o_cur_stridx", 32'(cur_o), 0);
        rst = 1'b0;
        ptr = '{0, 0, 0};
        got_q.delete();
        prev_hold = 1'b0;
        emit_done = 1'b0;
        stall_left = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (stall_left > 0) begin
            ready_i = 1'b0;
            stall_left--;
        end else if (stall_at >= 0 && got_q.size() == stall_at) begin
            ready_i = 1'b0;
            stall_left = 9;
            stall_at = -1;
        end else begin
            ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        emit = 1'b0;
        if (emit_at >= 0 && !emit_done && ptr[1] >= emit_at) begin
            emit = 1'b1;
            emit_done = 1'b1;
        end
        for (int k = 0; k < N; k++) data[k*8 +: 8] = (ptr[k] < 128) ? src[k][ptr[k]] : 8'h00;
        #1;
        if (prev_hold) begin
            check("hold_o_valid", 32'(ovalid), 1);
            check("hold_o_data", 32'(odata), 32'(prev_data));
        end
        if (ovalid && !ready_i) check("ready_while_stalled", 32'(ready_o), 0);
        for (int k = 0; k < N; k++)
            if (!(en[k] && cfg_b[k] > 0)) check($sformatf("masked_ready%0d", k), 32'(ready_o[k]), 0);
        prev_hold = ovalid && !ready_i;
        prev_data = odata;
        if (ovalid && ready_i && got_q.size() < nwant) got_q.push_back(odata);
        for (int k = 0; k < N; k++) if (valid[k] && ready_o[k]) ptr[k]++;
    endtask

    task automatic run(input string name, input int n);
        int cyc;
        build_model(1'b0, en, cfg_b[0], cfg_b[1], cfg_b[2], 0, emit_after, n);
        exp_q = mdl_q;
        burst = {8'(cfg_b[2]), 8'(cfg_b[1]), 8'(cfg_b[0])};
        do_reset();
        valid = en;
        nwant = n;
        cyc = 0;
        while (got_q.size() < nwant && cyc < 3000) begin
            step();
            cyc++;
        end
        if (got_q.size() < nwant) check({name, "_timeout"}, 32'(got_q.size()), 32'(nwant));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        valid = '0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 128; i++) src[k][i] = rbyte();
    endtask

    task automatic defaults();
        emit_at = -1; emit_after = -1; stall_at = -1; rand_ready = 1'b1;
        fill_random();
    endtask

    // Refresh-period instance: stream 2 only, sink always ready.
    initial begin
        int pcyc;
        p_rst = 1'b1; p_valid = '0; p_ready_i = 1'b1; p_emit = 1'b0; p_data = '0;
        p_burst = {8'd5, 8'd3, 8'd3};
        pptr = 0; p_done = 1'b0; pcyc = 0;
        for (int i = 0; i < 128; i++) psrc[i] = rbyte();
        repeat (3) @(negedge clk);
        p_rst = 1'b0;
        p_valid = 3'b100;
        while (pgot_q.size() < 64 && pcyc < 2000) begin
            @(negedge clk);
            p_data[23:16] = (pptr < 128) ? psrc[pptr] : 8'h00;
            #1;
            if (p_ovalid && p_ready_i) pgot_q.push_back(p_odata);
            if (p_valid[2] && p_ready_o[2]) pptr++;
            pcyc++;
        end
        p_valid = '0;
        p_done = 1'b1;
    end

    initial begin
        int b [3];
        rst = 1'b1; valid = '0; emit = 1'b0; ready_i = 1'b1; data = '0; burst = '0;
        en = '0; cfg_b = '{0, 0, 0}; nwant = 0; stall_left = 0;

        defaults();
        for (int i = 0; i < 128; i++) src[0][i] = 8'(i);
        rand_ready = 1'b0;
        en = 3'b001; cfg_b = '{4, 4, 4};
        run("single_stream", 40);

        defaults();
        en = 3'b011; cfg_b = '{2, 3, 4};
        run("two_streams", 45);

        defaults();
        for (int i = 0; i < 4; i++) src[1][i] = 8'h1A + 8'(i);
        en = 3'b011; cfg_b = '{3, 4, 4};
        run("esc_dup", 40);

        defaults();
        rand_ready = 1'b0; stall_at = 5;
        en = 3'b100; cfg_b = '{1, 1, 6};
        run("sink_stall", 30);

        defaults();
        emit_at = 6; emit_after = 2;
        en = 3'b010; cfg_b = '{4, 4, 4};
        run("emit_refresh", 30);

        defaults();
        en = 3'b111; cfg_b = '{3, 2, 0};
        run("burst_zero", 40);

        for (int r = 0; r < 6; r++) begin
            defaults();
            do begin
                en = 3'($urandom_range(1, 7));
                for (int k = 0; k < N; k++) b[k] = $urandom_range(0, 5);
            end while (!((en[0] && b[0] > 0) || (en[1] && b[1] > 0) || (en[2] && b[2] > 0)));
            cfg_b = b;
            run($sformatf("random%0d", r), 45);
        end

        wait (p_done);
        build_model(1'b1, 3'b100, 3, 3, 5, 16, -1, 64);
        if (pgot_q.size() < 64) check("period_timeout", 32'(pgot_q.size()), 64);
        for (int i = 0; i < pgot_q.size() && i < mdl_q.size(); i++)
            check($sformatf("period_byte%0d", i), 32'(pgot_q[i]), 32'(mdl_q[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
